// File: rtl/axis_sqr_acc.sv
// AXI-Stream squarer: elastic multi-stage square pipeline feeding either a per-beat output
// (MODE 0) or a saturating per-packet sum-of-squares accumulator (MODE 1).
module axis_sqr_acc #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned SIGNED     = 0,
    parameter int unsigned MODE       = 0,
    parameter int unsigned MUL_STAGES = 1,
    parameter int unsigned ACC_W      = 2 * WIDTH + 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [ACC_W-1:0] m_axis_tdata,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser
);
    localparam int unsigned NS = MUL_STAGES + 2;
    localparam int unsigned PW = 2 * WIDTH + 1;

    typedef enum logic {StAcc, StHold} acc_st_e;

    if (WIDTH < 2) begin : g_bad_width
        $error("WIDTH must be at least 2");
    end
    if (ACC_W < 2 * WIDTH) begin : g_bad_acc_w
        $error("ACC_W must be at least 2*WIDTH");
    end
    if (MUL_STAGES < 1 || MUL_STAGES > 4) begin : g_bad_stages
        $error("MUL_STAGES must be 1..4");
    end
    if (MODE > 1) begin : g_bad_mode
        $error("MODE must be 0 or 1");
    end

    // Stage payload is {tlast, data}; stage 0 holds the raw sample, later stages the square.
    logic [PW-1:0] st_dat [NS];
    logic          st_vld [NS];
    logic          st_rdy [NS];
    logic          last_rdy;

    logic signed [2*WIDTH+1:0] x_ext;
    logic signed [2*WIDTH+1:0] prod;
    logic        [2*WIDTH-1:0] sq;
    logic                      x_msb;
    logic                      unused_bits;

    assign x_msb       = (SIGNED != 0) ? st_dat[0][WIDTH-1] : 1'b0;
    assign x_ext       = {{(WIDTH + 2){x_msb}}, st_dat[0][WIDTH-1:0]};
    assign prod        = x_ext * x_ext;
    assign sq          = prod[2*WIDTH-1:0];
    assign unused_bits = ^{prod[2*WIDTH+1:2*WIDTH], st_dat[0][2*WIDTH-1:WIDTH]};

    for (genvar i = 0; i < NS; i++) begin : g_stage
        logic          in_vld;
        logic          out_rdy;
        logic          in_fire;
        logic [PW-1:0] in_dat;
        logic [PW-1:0] main_q, main_d, skid_q, skid_d;
        logic          main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, rdy_q, rdy_d;

        if (i == 0) begin : g_in
            assign in_vld = s_axis_tvalid;
            assign in_dat = {s_axis_tlast, {WIDTH{1'b0}}, s_axis_tdata};
        end else if (i == 1) begin : g_sq
            assign in_vld = st_vld[0];
            assign in_dat = {st_dat[0][PW-1], sq};
        end else begin : g_dly
            assign in_vld = st_vld[i-1];
            assign in_dat = st_dat[i-1];
        end

        if (i == NS - 1) begin : g_tail
            assign out_rdy = last_rdy;
        end else begin : g_mid
            assign out_rdy = st_rdy[i+1];
        end

        assign in_fire = in_vld && rdy_q;

        // Skid entry only fills when the main entry is full and stalled; ready is its inverse.
        always_comb begin
            main_d     = main_q;
            main_vld_d = main_vld_q;
            skid_d     = skid_q;
            skid_vld_d = skid_vld_q;
            if (out_rdy || !main_vld_q) begin
                if (skid_vld_q) begin
                    main_d     = skid_q;
                    main_vld_d = 1'b1;
                    skid_vld_d = 1'b0;
                end else begin
                    main_vld_d = in_fire;
                    if (in_fire) main_d = in_dat;
                end
            end else if (in_fire) begin
                skid_d     = in_dat;
                skid_vld_d = 1'b1;
            end
            rdy_d = !skid_vld_d;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                main_q     <= '0;
                skid_q     <= '0;
                main_vld_q <= 1'b0;
                skid_vld_q <= 1'b0;
                rdy_q      <= 1'b0;
            end else begin
                main_q     <= main_d;
                skid_q     <= skid_d;
                main_vld_q <= main_vld_d;
                skid_vld_q <= skid_vld_d;
                rdy_q      <= rdy_d;
            end
        end

        assign st_dat[i] = main_q;
        assign st_vld[i] = main_vld_q;
        assign st_rdy[i] = rdy_q;
    end

    assign s_axis_tready = st_rdy[0];

    if (MODE == 0) begin : g_beat
        assign last_rdy      = m_axis_tready;
        assign m_axis_tvalid = st_vld[NS-1];
        assign m_axis_tlast  = st_dat[NS-1][PW-1];
        assign m_axis_tuser  = 1'b0;
        always_comb begin
            m_axis_tdata              = '0;
            m_axis_tdata[2*WIDTH-1:0] = st_dat[NS-1][2*WIDTH-1:0];
        end
    end else begin : g_acc
        acc_st_e          st_q;
        logic [ACC_W-1:0] acc_q, sq_ext, acc_nxt, out_dat_q;
        logic [ACC_W:0]   sum;
        logic             sat_q, sat_nxt, out_vld_q, out_last_q, out_user_q;
        logic             take, tl, out_free;

        always_comb begin
            sq_ext              = '0;
            sq_ext[2*WIDTH-1:0] = st_dat[NS-1][2*WIDTH-1:0];
        end

        assign sum      = {1'b0, acc_q} + {1'b0, sq_ext};
        assign sat_nxt  = sat_q || sum[ACC_W];
        assign acc_nxt  = sat_nxt ? '1 : sum[ACC_W-1:0];
        assign last_rdy = (st_q == StAcc);
        assign take     = st_vld[NS-1] && (st_q == StAcc);
        assign tl       = st_dat[NS-1][PW-1];
        assign out_free = !out_vld_q || m_axis_tready;

        // HOLD parks a finished sum in the accumulator while the output register is stalled.
        always_ff @(posedge clk) begin
            if (rst) begin
                st_q       <= StAcc;
                acc_q      <= '0;
                sat_q      <= 1'b0;
                out_vld_q  <= 1'b0;
                out_dat_q  <= '0;
                out_last_q <= 1'b0;
                out_user_q <= 1'b0;
            end else begin
                if (out_vld_q && m_axis_tready) out_vld_q <= 1'b0;
                unique case (st_q)
                    StAcc: begin
                        if (take && tl && out_free) begin
                            out_vld_q  <= 1'b1;
                            out_dat_q  <= acc_nxt;
                            out_user_q <= sat_nxt;
                            out_last_q <= 1'b1;
                            acc_q      <= '0;
                            sat_q      <= 1'b0;
                        end else if (take) begin
                            acc_q <= acc_nxt;
                            sat_q <= sat_nxt;
                            if (tl) st_q <= StHold;
                        end
                    end
                    StHold: begin
                        if (out_vld_q && m_axis_tready) begin
                            out_vld_q  <= 1'b1;
                            out_dat_q  <= acc_q;
                            out_user_q <= sat_q;
                            out_last_q <= 1'b1;
                            acc_q      <= '0;
                            sat_q      <= 1'b0;
                            st_q       <= StAcc;
                        end
                    end
                    default: st_q <= StAcc;
                endcase
            end
        end

        assign m_axis_tvalid = out_vld_q;
        assign m_axis_tdata  = out_dat_q;
        assign m_axis_tlast  = out_last_q;
        assign m_axis_tuser  = out_user_q;
    end

endmodule

// File: tb/tb_axis_sqr_acc.sv
// Scoreboard bench for axis_sqr_acc: three configurations share one stimulus bus and the
// selected instance is observed through a mux.
module tb_axis_sqr_acc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, s_vld, s_last, m_rdy;
    logic [15:0] s_dat;

    logic        a_s_rdy, a_m_vld, a_m_last, a_m_user;
    logic [39:0] a_m_dat;
    logic        b_s_rdy, b_m_vld, b_m_last, b_m_user;
    logic [39:0] b_m_dat;
    logic        c_s_rdy, c_m_vld, c_m_last, c_m_user;
    logic [31:0] c_m_dat;

    axis_sqr_acc #(.WIDTH(16), .SIGNED(0), .MODE(0), .MUL_STAGES(1)) u_a (
        .clk(clk), .rst(rst), .s_axis_tvalid(s_vld), .s_axis_tready(a_s_rdy),
        .s_axis_tdata(s_dat), .s_axis_tlast(s_last), .m_axis_tvalid(a_m_vld),
        .m_axis_tready(m_rdy), .m_axis_tdata(a_m_dat), .m_axis_tlast(a_m_last),
        .m_axis_tuser(a_m_user)
    );
    axis_sqr_acc #(.WIDTH(16), .SIGNED(1), .MODE(0), .MUL_STAGES(2)) u_b (
        .clk(clk), .rst(rst), .s_axis_tvalid(s_vld), .s_axis_tready(b_s_rdy),
        .s_axis_tdata(s_dat), .s_axis_tlast(s_last), .m_axis_tvalid(b_m_vld),
        .m_axis_tready(m_rdy), .m_axis_tdata(b_m_dat), .m_axis_tlast(b_m_last),
        .m_axis_tuser(b_m_user)
    );
    axis_sqr_acc #(.WIDTH(16), .SIGNED(0), .MODE(1), .MUL_STAGES(1), .ACC_W(32)) u_c (
        .clk(clk), .rst(rst), .s_axis_tvalid(s_vld), .s_axis_tready(c_s_rdy),
        .s_axis_tdata(s_dat), .s_axis_tlast(s_last), .m_axis_tvalid(c_m_vld),
        .m_axis_tready(m_rdy), .m_axis_tdata(c_m_dat), .m_axis_tlast(c_m_last),
        .m_axis_tuser(c_m_user)
    );

    int          sel;
    logic        s_rdy, m_vld, m_last, m_user;
    logic [39:0] m_dat;

    always_comb begin
        s_rdy = c_s_rdy; m_vld = c_m_vld; m_last = c_m_last; m_user = c_m_user;
        m_dat = {8'd0, c_m_dat};
        case (sel)
            0: begin
                s_rdy = a_s_rdy; m_vld = a_m_vld; m_last = a_m_last; m_user = a_m_user;
                m_dat = a_m_dat;
            end
            1: begin
                s_rdy = b_s_rdy; m_vld = b_m_vld; m_last = b_m_last; m_user = b_m_user;
                m_dat = b_m_dat;
            end
            default: ;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          total = 0;
    int          bad = 0;
    int          acc_cyc, out_cyc, stab_err, send_to;
    logic        prev_stall;
    logic [41:0] prev_out;
    logic [41:0] exp_q[$];
    bit          done;

    task automatic do_reset();
        rst = 1'b1; s_vld = 1'b0; s_last = 1'b0; s_dat = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        prev_stall = 1'b0; stab_err = 0; send_to = 0;
    endtask

    // Holds the beat on the bus until the selected DUT accepts it; returns at edge+1.
    task automatic send_beat(input logic [15:0] x, input logic l);
        bit ok;
        ok = 0;
        s_vld = 1'b1; s_dat = x; s_last = l;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            ok = s_rdy;
            if (ok) acc_cyc = cyc + 1;
            @(posedge clk);
            #1;
        end
        if (!ok) send_to++;
    endtask

    // Waits for the next output handshake, tracking output stability during stalls.
    task automatic get_beat(output logic [39:0] d, output logic l, output logic u,
                            output bit got);
        got = 0; d = '0; l = 1'b0; u = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (prev_stall && (!m_vld || {m_user, m_last, m_dat} !== prev_out)) stab_err++;
            if (m_vld && m_rdy) begin
                d = m_dat; l = m_last; u = m_user; got = 1; out_cyc = cyc;
                prev_stall = 1'b0;
            end else begin
                prev_stall = m_vld;
                prev_out   = {m_user, m_last, m_dat};
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_vld = 1'b1; s_dat = 16'd9; s_last = 1'b1; m_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({a_s_rdy, a_m_vld, a_m_last, a_m_user} !== 4'b0) begin
            bad++; $display("FAIL reset_a rdy/vld/last/user=%b required 0000",
                            {a_s_rdy, a_m_vld, a_m_last, a_m_user});
        end
        total++;
        if ({b_s_rdy, b_m_vld, b_m_last, b_m_user} !== 4'b0) begin
            bad++; $display("FAIL reset_b rdy/vld/last/user=%b required 0000",
                            {b_s_rdy, b_m_vld, b_m_last, b_m_user});
        end
        total++;
        if ({c_s_rdy, c_m_vld, c_m_last, c_m_user} !== 4'b0) begin
            bad++; $display("FAIL reset_c rdy/vld/last/user=%b required 0000",
                            {c_s_rdy, c_m_vld, c_m_last, c_m_user});
        end
        rst = 1'b0; s_vld = 1'b0;
        @(negedge clk);
        total++;
        if ({a_s_rdy, b_s_rdy, c_s_rdy} !== 3'b111) begin
            bad++; $display("FAIL ready_after_reset a/b/c=%b required 111",
                            {a_s_rdy, b_s_rdy, c_s_rdy});
        end
        total++;
        if ({a_m_vld, b_m_vld, c_m_vld} !== 3'b000) begin
            bad++; $display("FAIL idle_after_reset vld a/b/c=%b required 000",
                            {a_m_vld, b_m_vld, c_m_vld});
        end
    endtask

    task automatic test_mode0_basic();
        logic [39:0] d; logic l, u; bit got; logic [41:0] e; int first_acc, prev_o;
        sel = 0; m_rdy = 1'b1; do_reset();
        exp_q.push_back({2'b00, 40'd9});
        exp_q.push_back({2'b00, 40'd4294836225});
        exp_q.push_back({2'b01, 40'd0});
        fork
            begin
                send_beat(16'd3, 1'b0); first_acc = acc_cyc;
                send_beat(16'd65535, 1'b0);
                send_beat(16'd0, 1'b1);
                s_vld = 1'b0;
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    get_beat(d, l, u, got);
                    e = exp_q.pop_front();
                    total++;
                    if (!got || {u, l, d} !== e) begin
                        bad++; $display("FAIL mode0_beat%0d got=%0d data=%0d last=%b user=%b required %0d/%b/%b",
                                        k, got, d, l, u, e[39:0], e[40], e[41]);
                    end
                    total++;
                    if (k == 0 && out_cyc - first_acc !== 2) begin
                        bad++; $display("FAIL mode0_latency %0d required 2", out_cyc - first_acc);
                    end else if (k > 0 && out_cyc - prev_o !== 1) begin
                        bad++; $display("FAIL mode0_consecutive gap=%0d required 1", out_cyc - prev_o);
                    end
                    prev_o = out_cyc;
                end
            end
        join
    endtask

    task automatic test_signed();
        logic [39:0] d; logic l, u; bit got; logic [41:0] e; int first_acc;
        sel = 1; m_rdy = 1'b1; do_reset();
        exp_q.push_back({2'b00, 40'd1073741824});
        exp_q.push_back({2'b01, 40'd25});
        fork
            begin
                send_beat(16'h8000, 1'b0); first_acc = acc_cyc;
                send_beat(16'hFFFB, 1'b1);
                s_vld = 1'b0;
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    get_beat(d, l, u, got);
                    e = exp_q.pop_front();
                    total++;
                    if (!got || {u, l, d} !== e) begin
                        bad++; $display("FAIL signed_beat%0d got=%0d data=%0d last=%b required %0d/%b",
                                        k, got, d, l, e[39:0], e[40]);
                    end
                    if (k == 0) begin
                        total++;
                        if (out_cyc - first_acc !== 3) begin
                            bad++; $display("FAIL signed_latency %0d required 3", out_cyc - first_acc);
                        end
                    end
                end
            end
        join
    endtask

    task automatic test_packets();
        logic [39:0] d; logic l, u; bit got; logic [41:0] e; int last_acc;
        sel = 2; m_rdy = 1'b1; do_reset();
        exp_q.push_back({2'b01, 40'd14});
        exp_q.push_back({2'b01, 40'd16});
        fork
            begin
                send_beat(16'd1, 1'b0);
                send_beat(16'd2, 1'b0);
                send_beat(16'd3, 1'b1); last_acc = acc_cyc;
                send_beat(16'd4, 1'b1);
                s_vld = 1'b0;
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    get_beat(d, l, u, got);
                    e = exp_q.pop_front();
                    total++;
                    if (!got || {u, l, d} !== e) begin
                        bad++; $display("FAIL packet%0d got=%0d sum=%0d last=%b user=%b required %0d/1/0",
                                        k, got, d, l, u, e[39:0]);
                    end
                    if (k == 0) begin
                        total++;
                        if (out_cyc - last_acc !== 3) begin
                            bad++; $display("FAIL packet_latency %0d required 3", out_cyc - last_acc);
                        end
                    end
                end
            end
        join
    endtask

    task automatic test_saturation();
        logic [39:0] d; logic l, u; bit got; logic [41:0] e;
        sel = 2; m_rdy = 1'b1; do_reset();
        exp_q.push_back({2'b11, 40'd4294967295});
        exp_q.push_back({2'b01, 40'd4});
        fork
            begin
                send_beat(16'd65535, 1'b0);
                send_beat(16'd65535, 1'b1);
                send_beat(16'd2, 1'b1);
                s_vld = 1'b0;
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    get_beat(d, l, u, got);
                    e = exp_q.pop_front();
                    total++;
                    if (!got || {u, l, d} !== e) begin
                        bad++; $display("FAIL saturation%0d got=%0d sum=%0d user=%b required %0d/%b",
                                        k, got, d, u, e[39:0], e[41]);
                    end
                end
            end
        join
    endtask

    task automatic test_hold();
        logic [39:0] d; logic l, u; bit got; logic [41:0] e;
        sel = 2; m_rdy = 1'b0; do_reset();
        for (int k = 1; k <= 5; k++) exp_q.push_back({2'b01, 40'(k * k)});
        fork
            begin
                for (int k = 1; k <= 5; k++) send_beat(16'(k), 1'b1);
                s_vld = 1'b0;
                repeat (10) @(posedge clk);
                #1 m_rdy = 1'b1;
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    get_beat(d, l, u, got);
                    e = exp_q.pop_front();
                    total++;
                    if (!got || {u, l, d} !== e) begin
                        bad++; $display("FAIL hold_pkt%0d got=%0d sum=%0d required %0d",
                                        k, got, d, e[39:0]);
                    end
                end
            end
        join
        total++;
        if (stab_err !== 0 || send_to !== 0) begin
            bad++; $display("FAIL hold_stability unstable=%0d timeouts=%0d required 0/0",
                            stab_err, send_to);
        end
    endtask

    task automatic test_reset_midpacket();
        logic [39:0] d; logic l, u; bit got; logic [41:0] e; int extra;
        sel = 2; m_rdy = 1'b1; do_reset();
        send_beat(16'd5, 1'b0);
        send_beat(16'd6, 1'b0);
        s_vld = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.push_back({2'b01, 40'd49});
        send_beat(16'd7, 1'b1);
        s_vld = 1'b0;
        get_beat(d, l, u, got);
        e = exp_q.pop_front();
        total++;
        if (!got || {u, l, d} !== e) begin
            bad++; $display("FAIL reset_midpacket got=%0d sum=%0d required 49", got, d);
        end
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_vld) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++; $display("FAIL reset_midpacket_extra valid_cycles=%0d required 0", extra);
        end
    endtask

    task automatic test_random_mode0();
        logic [39:0] d; logic l, u; bit got; logic [41:0] e; int extra;
        sel = 1; m_rdy = 1'b1; do_reset(); done = 0;
        fork
            begin
                logic [15:0] x; logic signed [15:0] xs; logic xl; longint sq;
                for (int k = 0; k < 1000; k++) begin
                    x = 16'($urandom); xl = 1'($urandom_range(0, 1)); xs = $signed(x);
                    sq = longint'(xs) * longint'(xs);
                    exp_q.push_back({1'b0, xl, sq[39:0]});
                    send_beat(x, xl);
                    if ($urandom_range(0, 3) == 0) begin
                        s_vld = 1'b0; @(posedge clk); #1;
                    end
                end
                s_vld = 1'b0;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #2 m_rdy = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int k = 0; k < 1000; k++) begin
                    get_beat(d, l, u, got);
                    total++;
                    if (!got || exp_q.size() == 0) begin
                        bad++; $display("FAIL rand0_beat%0d got=%0d pending=%0d required handshake with pending",
                                        k, got, exp_q.size());
                        break;
                    end
                    e = exp_q.pop_front();
                    if ({u, l, d} !== e) begin
                        bad++; $display("FAIL rand0_beat%0d data=%0d last=%b user=%b required %0d/%b/0",
                                        k, d, l, u, e[39:0], e[40]);
                    end
                end
                done = 1;
            end
        join
        m_rdy = 1'b1; extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_vld) extra++;
        end
        total++;
        if (stab_err !== 0 || exp_q.size() !== 0 || extra !== 0 || send_to !== 0) begin
            bad++; $display("FAIL rand0_integrity unstable=%0d pending=%0d extra=%0d timeouts=%0d required 0/0/0/0",
                            stab_err, exp_q.size(), extra, send_to);
        end
    endtask

    task automatic test_random_mode1();
        logic [39:0] d; logic l, u; bit got; logic [41:0] e; int extra;
        sel = 2; m_rdy = 1'b1; do_reset(); done = 0;
        fork
            begin
                logic [15:0] x; longint macc, sum; bit msat; int len;
                for (int p = 0; p < 150; p++) begin
                    len = $urandom_range(1, 4); macc = 0; msat = 0;
                    for (int b = 0; b < len; b++) begin
                        x = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4000));
                        sum = macc + longint'(x) * longint'(x);
                        if (msat || sum > 64'hFFFF_FFFF) begin
                            msat = 1; macc = 64'hFFFF_FFFF;
                        end else begin
                            macc = sum;
                        end
                        if (b == len - 1) exp_q.push_back({msat, 1'b1, 8'd0, macc[31:0]});
                        send_beat(x, b == len - 1);
                    end
                    if ($urandom_range(0, 3) == 0) begin
                        s_vld = 1'b0; @(posedge clk); #1;
                    end
                end
                s_vld = 1'b0;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #2 m_rdy = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int k = 0; k < 150; k++) begin
                    get_beat(d, l, u, got);
                    total++;
                    if (!got || exp_q.size() == 0) begin
                        bad++; $display("FAIL rand1_pkt%0d got=%0d pending=%0d required handshake with pending",
                                        k, got, exp_q.size());
                        break;
                    end
                    e = exp_q.pop_front();
                    if ({u, l, d} !== e) begin
                        bad++; $display("FAIL rand1_pkt%0d sum=%0d last=%b user=%b required %0d/1/%b",
                                        k, d, l, u, e[39:0], e[41]);
                    end
                end
                done = 1;
            end
        join
        m_rdy = 1'b1; extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_vld) extra++;
        end
        total++;
        if (stab_err !== 0 || exp_q.size() !== 0 || extra !== 0 || send_to !== 0) begin
            bad++; $display("FAIL rand1_integrity unstable=%0d pending=%0d extra=%0d timeouts=%0d required 0/0/0/0",
                            stab_err, exp_q.size(), extra, send_to);
        end
    endtask

    initial begin
        sel = 0; rst = 1'b1; s_vld = 1'b0; s_dat = '0; s_last = 1'b0; m_rdy = 1'b1;
        prev_stall = 1'b0; stab_err = 0; send_to = 0; done = 0;
        test_reset();
        test_mode0_basic();
        test_signed();
        test_packets();
        test_saturation();
        test_hold();
        test_reset_midpacket();
        test_random_mode0();
        test_random_mode1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
